// File: rtl/nested_src_fifo.sv
// nested_src_fifo: first-word fall-through FIFO feeding nested_top.top_in.
// Define NESTED_SRC_FIFO_DROP_CNT_EN to add a saturating drop_cnt output for refused pushes.
module nested_src_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count
`ifdef NESTED_SRC_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]                 drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;
    // DEPTH is a power of two, so pointer wrap is plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
`ifdef NESTED_SRC_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (in_valid && !in_ready && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif
endmodule

// File: doc/nested_src_fifo.md
Name: nested_src_fifo

Overview:
- Small synchronous FIFO directly upstream of nested_top; its out_data drives top_in.
- Decouples a bursty 4-bit producer from the nested_top → nested_mid → nested_leaf pass-through chain with a valid/ready handshake on both sides.
- First-word fall-through: the head entry is visible on out_data while out_valid=1.

Parameters:
- WIDTH, 4, data width; must equal the top_in width of nested_top.
- DEPTH, 4, number of entries; power of two, ≥2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  FIFO can accept; equals !full.
- in_data  input  WIDTH  write data.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  consumer takes head this cycle.
- out_data  output  WIDTH  head entry, to nested_top.top_in.
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous and active-low (rst_n); all state clears immediately on assertion, independent of clk.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, out_data=0. Storage array is not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same rising edge.
- push: mem[wr_ptr] <= in_data; wr_ptr increments, wrapping DEPTH-1 → 0.
- pop: rd_ptr increments, wrapping DEPTH-1 → 0.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: data pushed into an empty FIFO appears on out_data with out_valid=1 the cycle after the push edge. No same-cycle bypass.
- out_data = mem[rd_ptr] when out_valid=1, else forced to 0 (combinational gate).
- Full (count==DEPTH): in_ready=0. A push attempt is ignored, and in_data is not stored even if a pop happens in the same cycle. in_ready rises the cycle after a pop.
- Empty (count==0): out_valid=0, and out_ready is ignored.
- Simultaneous push and pop at 0<count<DEPTH: both take effect; count unchanged; FIFO order preserved.
- Ordering: strict FIFO; no reordering, duplication or loss of accepted data.
- in_ready and out_valid depend only on registered state. There is no combinational path from in_valid or out_ready to any output.
- Reset mid-operation: all queued entries are discarded; the first post-reset push is the next head.
- in_data is sampled only on a push edge; its value at other times is don't-care.

Optional Feature:
- Macro: NESTED_SRC_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt [7:0].
  - drop_cnt increments on each rising edge with in_valid=1 and in_ready=0.
  - Saturates at 255; resets to 0 on rst_n low.
- Undefined:
  - Port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle → count=0, in_ready=1, out_valid=0, out_data=0; assert rst_n low between clk edges → outputs clear immediately.
- Push 0x3 with out_ready=0 → next cycle out_valid=1, out_data=0x3, count=1.
- Push 0x1,0x2,0x3,0x4 with out_ready=0 → count=4, in_ready=0. Push 0x5 → ignored. Then hold out_ready=1 → out_data sequence 1,2,3,4, then out_valid=0.
- At count=2, hold in_valid=1 and out_ready=1 for 6 cycles with data 0x6..0xB → count stays 2 throughout; pops appear in push order; pointers wrap with no loss.
- At count=3 holding 0xA,0xB,0xC, pulse rst_n low → count=0, out_valid=0. Push 0xD → out_data=0xD next cycle.
- With NESTED_SRC_FIFO_DROP_CNT_EN: fill to 4, then hold in_valid=1 for 300 cycles with out_ready=0 → drop_cnt=255, saturated.
